// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment capture block: active-low hex segment
// patterns (c[0]=seg a .. c[6]=seg g), the blank pattern and FSM state codes.
package ssd_pkg;

   localparam logic [6:0] BLANK = 7'b1111111;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   function automatic logic one_low(input logic [3:0] an);
      return an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
   endfunction

   function automatic logic many_low(input logic [3:0] an);
      return (an != 4'b1111) && !one_low(an);
   endfunction

endpackage

// File: rtl/ssd_decoder.sv
// Combinational segment-pattern to hex decode; blank and unknown patterns
// both yield value 0, distinguished by the blank and valid flags.
module ssd_decoder
   import ssd_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] value,
   output logic       blank,
   output logic       valid
);

   always_comb begin
      value = '0;
      blank = (seg == BLANK);
      valid = blank;
      for (int unsigned i = 0; i < 16; i++) begin
         if (seg == HEX_SEG[i]) begin
            value = 4'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ssd_capture.sv
// Reconstructs the four hex digits shown on a multiplexed, active-low
// seven-segment display by watching its anode and segment lines.
module ssd_capture #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  a,
   input  logic [6:0]  c,
   output logic [15:0] digits,
   output logic [3:0]  blank,
   output logic        frame_valid,
   output logic        seg_err,
   output logic        anode_err
);
   import ssd_pkg::*;

   localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

   logic [3:0] a_q, a_p;
   logic [6:0] c_q, c_p;
   logic [1:0] state;
   logic [7:0] count;
   logic [3:0] mask;
   logic [3:0] shadow_val [4];
   logic [3:0] shadow_blank;

   logic [3:0] dec_val;
   logic       dec_blank, dec_valid;
   logic [1:0] sel;
   logic       changed, hold_same, capture;
   logic [7:0] count_n;

   ssd_decoder u_dec (
      .seg   (c_q),
      .value (dec_val),
      .blank (dec_blank),
      .valid (dec_valid)
   );

   // a_p/c_p are last cycle's registered samples; any difference restarts settling.
   always_comb begin
      sel = 2'd0;
      case (a_q)
         4'b1101: sel = 2'd1;
         4'b1011: sel = 2'd2;
         4'b0111: sel = 2'd3;
         default: sel = 2'd0;
      endcase
      changed   = (a_q != a_p) || (c_q != c_p);
      hold_same = (state == ST_HOLD) && !changed;
      count_n   = ((state == ST_SETTLE) && !changed) ? count + 8'd1 : 8'd1;
      capture   = one_low(a_q) && !hold_same && (count_n >= SETTLE_N);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q          <= 4'b1111;
         c_q          <= BLANK;
         a_p          <= 4'b1111;
         c_p          <= BLANK;
         state        <= ST_IDLE;
         count        <= '0;
         mask         <= '0;
         shadow_blank <= '0;
         for (int unsigned i = 0; i < 4; i++) shadow_val[i] <= '0;
         digits       <= '0;
         blank        <= '1;
         frame_valid  <= 1'b0;
         seg_err      <= 1'b0;
         anode_err    <= 1'b0;
      end else begin
         a_q         <= a;
         c_q         <= c;
         a_p         <= a_q;
         c_p         <= c_q;
         anode_err   <= many_low(a_q) && !many_low(a_p);
         seg_err     <= capture && !dec_valid;
         frame_valid <= (mask == 4'b1111);

         // A capture landing on the publish cycle starts the next frame's mask.
         if (mask == 4'b1111) begin
            digits <= {shadow_val[3], shadow_val[2], shadow_val[1], shadow_val[0]};
            blank  <= shadow_blank;
         end
         mask <= ((mask == 4'b1111) ? 4'b0000 : mask) | (capture ? ~a_q : 4'b0000);

         if (capture) begin
            shadow_val[sel]   <= dec_val;
            shadow_blank[sel] <= dec_blank;
         end

         if (hold_same) begin
            state <= ST_HOLD;
         end else if (!one_low(a_q)) begin
            state <= ST_IDLE;
            count <= '0;
         end else if (capture) begin
            state <= ST_HOLD;
            count <= count_n;
         end else begin
            state <= ST_SETTLE;
            count <= count_n;
         end
      end
   end

endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture with SETTLE_CYCLES=4: inputs change on the
// falling edge, outputs are checked on the falling edge.
module tb_ssd_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  a;
   logic [6:0]  c;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic        frame_valid, seg_err, anode_err;

   int unsigned vecs = 0;
   int unsigned errs = 0;
   int unsigned fv_n = 0, se_n = 0, ae_n = 0;

   ssd_capture #(.SETTLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .a           (a),
      .c           (c),
      .digits      (digits),
      .blank       (blank),
      .frame_valid (frame_valid),
      .seg_err     (seg_err),
      .anode_err   (anode_err)
   );

   always #5 clk = ~clk;

   // pulse counters sampled just after each rising edge
   always begin
      @(posedge clk);
      #1;
      if (frame_valid) fv_n++;
      if (seg_err)     se_n++;
      if (anode_err)   ae_n++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Apply a/c at the current falling edge, then let n rising edges pass.
   task automatic hold(input logic [3:0] av, input logic [6:0] cv, input int n);
      a = av;
      c = cv;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      a   = 4'b1111;
      c   = 7'b1111111;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++; if (digits !== 16'h0000) begin errs++; $display("FAIL reset_digits got %h exp 0000", digits); end
      vecs++; if (blank !== 4'b1111) begin errs++; $display("FAIL reset_blank got %b exp 1111", blank); end
      vecs++; if ({frame_valid, seg_err, anode_err} !== 3'b000) begin
         errs++; $display("FAIL reset_pulses got %b exp 000", {frame_valid, seg_err, anode_err});
      end
      vecs++; if (dut.mask !== 4'b0000) begin errs++; $display("FAIL reset_mask got %b exp 0000", dut.mask); end
   endtask

   task automatic test_settle_latency();
      int unsigned f0;
      do_reset();
      f0 = fv_n;
      hold(4'b1110, 7'b1000000, 4);
      vecs++; if (dut.mask !== 4'b0000) begin errs++; $display("FAIL latency_edge4 mask got %b exp 0000", dut.mask); end
      hold(4'b1110, 7'b1000000, 1);
      vecs++; if (dut.mask !== 4'b0001) begin errs++; $display("FAIL latency_edge5 mask got %b exp 0001", dut.mask); end
      hold(4'b1110, 7'b1000000, 3);
      vecs++; if (fv_n - f0 !== 0) begin errs++; $display("FAIL latency_no_frame got %0d exp 0", fv_n - f0); end
   endtask

   task automatic test_frame();
      int unsigned f0;
      do_reset();
      f0 = fv_n;
      hold(4'b1110, 7'b1111001, 8);
      hold(4'b1101, 7'b0100100, 8);
      hold(4'b1011, 7'b0110000, 8);
      vecs++; if ({digits, blank} !== {16'h0000, 4'b1111}) begin
         errs++; $display("FAIL frame_early_update got %h/%b exp 0000/1111", digits, blank);
      end
      hold(4'b0111, 7'b1111111, 8);
      vecs++; if (fv_n - f0 !== 1) begin errs++; $display("FAIL frame_count got %0d exp 1", fv_n - f0); end
      vecs++; if (digits !== 16'h0321) begin errs++; $display("FAIL frame_digits got %h exp 0321", digits); end
      vecs++; if (blank !== 4'b1000) begin errs++; $display("FAIL frame_blank got %b exp 1000", blank); end
   endtask

   task automatic test_unstable();
      int unsigned f0;
      do_reset();
      f0 = fv_n;
      for (int k = 0; k < 8; k++)
         hold(4'b1110, (k % 2 == 0) ? 7'b1000000 : 7'b1111001, 3);
      vecs++; if (dut.mask !== 4'b0000) begin errs++; $display("FAIL unstable_mask got %b exp 0000", dut.mask); end
      vecs++; if (fv_n - f0 !== 0) begin errs++; $display("FAIL unstable_frame got %0d exp 0", fv_n - f0); end
   endtask

   task automatic test_anode_err();
      int unsigned e0;
      do_reset();
      e0 = ae_n;
      hold(4'b1100, 7'b1000000, 10);
      hold(4'b1111, 7'b1111111, 3);
      vecs++; if (ae_n - e0 !== 1) begin errs++; $display("FAIL anode_err_count got %0d exp 1", ae_n - e0); end
      vecs++; if (dut.mask !== 4'b0000) begin errs++; $display("FAIL anode_err_mask got %b exp 0000", dut.mask); end
   endtask

   task automatic test_seg_err();
      int unsigned s0, f0;
      do_reset();
      s0 = se_n;
      f0 = fv_n;
      hold(4'b1011, 7'b1010101, 4);
      vecs++; if (seg_err !== 1'b0) begin errs++; $display("FAIL seg_err_early got %b exp 0", seg_err); end
      hold(4'b1011, 7'b1010101, 1);
      vecs++; if (seg_err !== 1'b1) begin errs++; $display("FAIL seg_err_edge5 got %b exp 1", seg_err); end
      hold(4'b1011, 7'b1010101, 3);
      vecs++; if (se_n - s0 !== 1) begin errs++; $display("FAIL seg_err_count got %0d exp 1", se_n - s0); end
      hold(4'b1110, 7'b0000000, 8);
      hold(4'b1101, 7'b0000000, 8);
      hold(4'b0111, 7'b0000000, 8);
      vecs++; if (fv_n - f0 !== 1) begin errs++; $display("FAIL seg_err_frame got %0d exp 1", fv_n - f0); end
      vecs++; if (digits !== 16'h8088) begin errs++; $display("FAIL seg_err_digits got %h exp 8088", digits); end
      vecs++; if (blank !== 4'b0000) begin errs++; $display("FAIL seg_err_blank got %b exp 0000", blank); end
   endtask

   task automatic test_reset_mid_frame();
      int unsigned f0;
      do_reset();
      hold(4'b1110, 7'b1111001, 8);
      hold(4'b1101, 7'b0100100, 8);
      hold(4'b1011, 7'b0110000, 8);
      f0 = fv_n;
      do_reset();
      vecs++; if (dut.mask !== 4'b0000) begin errs++; $display("FAIL midreset_mask got %b exp 0000", dut.mask); end
      hold(4'b1110, 7'b0000000, 8);
      hold(4'b1101, 7'b0000000, 8);
      hold(4'b1011, 7'b0000000, 8);
      vecs++; if (fv_n - f0 !== 0) begin errs++; $display("FAIL midreset_partial got %0d exp 0", fv_n - f0); end
      hold(4'b0111, 7'b0000000, 8);
      vecs++; if (fv_n - f0 !== 1) begin errs++; $display("FAIL midreset_frame got %0d exp 1", fv_n - f0); end
      vecs++; if (digits !== 16'h8888) begin errs++; $display("FAIL midreset_digits got %h exp 8888", digits); end
      vecs++; if (blank !== 4'b0000) begin errs++; $display("FAIL midreset_blank got %b exp 0000", blank); end
   endtask

   task automatic test_back_to_back();
      logic [6:0]  pat   [3][4];
      logic [15:0] exp_d [3];
      logic [3:0]  exp_b [3];
      logic [3:0]  an    [4];
      int unsigned f0;
      pat[0] = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
      pat[1] = '{7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
      pat[2] = '{7'b0010000, 7'b0000110, 7'b0001110, 7'b1111111};
      exp_d  = '{16'hDCBA, 16'h7654, 16'h0FE9};
      exp_b  = '{4'b0000, 4'b0000, 4'b1000};
      an     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      for (int f = 0; f < 3; f++) begin
         f0 = fv_n;
         for (int d = 0; d < 4; d++) hold(an[d], pat[f][d], 8);
         vecs++; if (fv_n - f0 !== 1) begin errs++; $display("FAIL b2b%0d_count got %0d exp 1", f, fv_n - f0); end
         vecs++; if (digits !== exp_d[f]) begin errs++; $display("FAIL b2b%0d_digits got %h exp %h", f, digits, exp_d[f]); end
         vecs++; if (blank !== exp_b[f]) begin errs++; $display("FAIL b2b%0d_blank got %b exp %b", f, blank, exp_b[f]); end
      end
   endtask

   initial begin
      rst = 1'b1;
      a   = 4'b1111;
      c   = 7'b1111111;
      @(negedge clk);
      test_reset();
      test_settle_latency();
      test_frame();
      test_unstable();
      test_anode_err();
      test_seg_err();
      test_reset_mid_frame();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/ssd_capture.md
SSD_CAPTURE -- requirements
Module: ssd_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning consecutive identical registered samples required before a digit is captured (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port a  input  4  digit anodes, active-low; a[i]=0 selects digit i.
REQ-005 SHALL have port c  input  7  segments, active-low (0 = lit), c[0]=seg a … c[6]=seg g.
REQ-006 SHALL have port digits  output  16  captured hex values, digit i at bits [4i+3:4i].
REQ-007 SHALL have port blank  output  4  blank[i]=1 when digit i captured as 7'b1111111.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when digits/blank update.
REQ-009 SHALL have port seg_err  output  1  one-cycle pulse on capture of an undecodable segment pattern.
REQ-010 SHALL have port anode_err  output  1  one-cycle pulse when more than one anode goes low.

Function
REQ-011 SHALL register a and c once (a_q, c_q) before any decision logic.
REQ-012 SHALL implement FSM IDLE / SETTLE / HOLD driven by a_q, c_q.
REQ-013 IDLE: a_q=4'b1111 stays IDLE, no error; a_q one-hot-low goes to SETTLE with count=1; two or more low goes to IDLE and pulses anode_err once per entry into that condition.
REQ-014 SETTLE: a_q,c_q unchanged from previous cycle increments count; any change restarts count=1 on the new values (or goes to IDLE per REQ-013 rules).
REQ-015 SETTLE: when count reaches SETTLE_CYCLES, SHALL capture c_q into the shadow slot for the selected digit, set its bit in a 4-bit capture mask, and go to HOLD.
REQ-016 Capture latency SHALL be SETTLE_CYCLES+1 rising edges after a and c become stable (1 input register + settle count).
REQ-017 HOLD: stays while a_q,c_q unchanged; any change is treated as in IDLE (REQ-013) in the same cycle.
REQ-018 Decode SHALL map the 16 standard hex patterns to 0x0–0xF and 7'b1111111 to blank=1, value 0x0.
REQ-019 Any other pattern SHALL pulse seg_err on the capture cycle, store value 0x0 and blank=0, and still set the mask bit.
REQ-020 Re-capture of a digit already in the mask SHALL overwrite its shadow slot.
REQ-021 When the mask becomes 4'b1111, SHALL on the next cycle copy all shadow slots to digits/blank, pulse frame_valid, and clear the mask.
REQ-022 digits/blank SHALL change only on the frame_valid cycle.
REQ-023 anode_err and seg_err SHALL be able to assert on the same cycle; neither blocks capture of later digits.

Reset
REQ-024 rst SHALL force: FSM=IDLE, count=0, mask=0, shadow slots=0, a_q=4'b1111, c_q=7'b1111111, digits=16'h0000, blank=4'b1111, frame_valid=0, seg_err=0, anode_err=0.
REQ-025 rst asserted mid-settle or mid-frame SHALL discard the partial frame; no frame_valid until four new captures.

Structure
REQ-026 Shared package ssd_pkg SHALL hold the 16 hex segment patterns, the BLANK constant 7'b1111111, and the FSM state encoding.
REQ-027 Segment-to-hex decode SHALL be a combinational sub-module ssd_decoder (in: 7-bit pattern; out: 4-bit value, blank, valid).

Verification
REQ-028 SETTLE_CYCLES=4; a=4'b1110, c=7'b1000000 held 5 cycles -> slot 0 = 0x0 captured on 5th edge, no frame_valid.
REQ-029 Cycle a through 1110/1101/1011/0111 with c=7'b1111001, 7'b0100100, 7'b0110000, 7'b1111111, 8 cycles each -> one frame_valid, digits=16'h0321, blank=4'b1000.
REQ-030 a=4'b1110 with c toggling every 3 cycles -> no capture, no frame_valid.
REQ-031 a=4'b1100 for 10 cycles -> exactly one anode_err pulse, no capture.
REQ-032 c=7'b1010101 held on digit 2 -> single seg_err pulse, slot 2 = 0x0, blank[2]=0.
REQ-033 rst pulsed after three digits captured, then four digits 7'b0000000 -> frame_valid once, digits=16'h8888.
